uart_tx: RTL and testbench

UART transmitter: the sending end of the serial link whose receiver (`uart_rx`) sits under `final_project`. It accepts bytes over a valid/ready handshake and serialises them on `tx` as 8N1 frames (8N2 optional), least-significant bit first. A one-entry holding buffer lets the next byte be accepted mid-frame, so consecutive frames go out with no idle gap. Its bit timing matches the receiver's default of 32 clocks per bit, so the two can be wired in loopback for test.

---
 rtl/uart_tx.sv | 207 ++++++++++++++++++++
 tb/tb_uart_tx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//
// UART transmitter. Bytes arrive over a valid/ready handshake and leave on
// `tx` as 8N1 frames (8N2 when STOP_BITS = 2), least-significant bit first.
// A one-entry holding buffer lets the next byte be accepted while a frame is
// on the wire. The buffered byte is loaded at the edge that ends the last stop
// bit, so chained frames have no idle gap between them.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per bit, must be >= 2 (default 32)
//   STOP_BITS     number of stop bits, 1 or 2       (default 1)
//
// Ports
//   clk       in   single clock; all state changes on its rising edge
//   reset     in   synchronous, active-high
//   tx_data   in   byte to send; sampled only on a handshake
//   tx_valid  in   tx_data is valid
//   tx_ready  out  the block can accept a byte this cycle (combinational)
//   tx        out  serial line, registered, idles high
//   busy      out  a frame is in progress, registered
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int CLKS_PER_BIT = 32,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state_reg,    state_next;
    logic [CNT_W-1:0] cnt_reg,      cnt_next;
    logic [2:0]       bit_idx_reg,  bit_idx_next;
    logic             stop_idx_reg, stop_idx_next;
    logic [7:0]       shreg_reg,    shreg_next;
    logic [7:0]       buf_reg,      buf_next;
    logic             buf_full_reg, buf_full_next;
    logic             tx_reg,       tx_next;
    logic             busy_reg,     busy_next;

    logic             handshake;
    logic             bit_done;
    logic             frame_end;
    logic [7:0]       shreg_shifted;

    // Ready is withheld while reset is asserted so that no byte can be
    // accepted on the same edge that clears the block.
    assign tx_ready  = !buf_full_reg && !reset;
    assign handshake = tx_valid && tx_ready;

    assign bit_done  = (cnt_reg == CNT_LAST);
    // Last cycle of the last stop bit: the edge that ends the frame.
    assign frame_end = (state_reg == STOP) && bit_done && (stop_idx_reg == STOP_LAST);

    // Shift right towards bit 0; the vacated MSB is filled with 1 (never sent).
    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_shift
            assign shreg_shifted[gi] = shreg_reg[gi+1];
        end
    endgenerate
    assign shreg_shifted[7] = 1'b1;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        bit_idx_next  = bit_idx_reg;
        stop_idx_next = stop_idx_reg;
        shreg_next    = shreg_reg;
        buf_next      = buf_reg;
        buf_full_next = buf_full_reg;

        case (state_reg)
            IDLE: begin
                // From idle the byte bypasses the buffer, so ready stays high.
                if (handshake) begin
                    shreg_next = tx_data;
                    state_next = START;
                    cnt_next   = '0;
                end
            end

            START: begin
                if (bit_done) begin
                    cnt_next     = '0;
                    bit_idx_next = 3'd0;
                    state_next   = DATA;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            DATA: begin
                if (bit_done) begin
                    cnt_next   = '0;
                    shreg_next = shreg_shifted;
                    if (bit_idx_reg == 3'd7) begin
                        stop_idx_next = 1'b0;
                        state_next    = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            STOP: begin
                if (bit_done) begin
                    cnt_next = '0;
                    if (stop_idx_reg == STOP_LAST) begin
                        if (buf_full_reg) begin
                            shreg_next    = buf_reg;
                            buf_full_next = 1'b0;
                            state_next    = START;
                        end else if (handshake) begin
                            // Empty buffer and a byte offered on the final
                            // stop cycle: chain it directly.
                            shreg_next = tx_data;
                            state_next = START;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        stop_idx_next = stop_idx_reg + 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Mid-frame handshakes park the byte in the holding buffer. The
        // final-stop-cycle case was consumed directly above.
        if (handshake && (state_reg != IDLE) && !frame_end) begin
            buf_next      = tx_data;
            buf_full_next = 1'b1;
        end
    end

    // Line level and busy are derived from the next state so that both flops
    // change on the same edge as the FSM (start bit appears at the
    // handshake edge) while tx still comes straight from a flop.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shreg_next[0];
            default: tx_next = 1'b1;
        endcase
        busy_next = (state_next != IDLE);
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            bit_idx_reg  <= 3'd0;
            stop_idx_reg <= 1'b0;
            shreg_reg    <= 8'hFF;
            buf_reg      <= 8'h00;
            buf_full_reg <= 1'b0;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bit_idx_reg  <= bit_idx_next;
            stop_idx_reg <= stop_idx_next;
            shreg_reg    <= shreg_next;
            buf_reg      <= buf_next;
            buf_full_reg <= buf_full_next;
            tx_reg       <= tx_next;
            busy_reg     <= busy_next;
        end
    end

    assign tx   = tx_reg;
    assign busy = busy_reg;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//
// Directed bench for uart_tx. Two instances share clock and reset: one at the
// defaults (32 clocks/bit, 1 stop bit) and one at 4 clocks/bit, 2 stop bits.
// Expected line levels are computed from the byte and bit timing.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       reset;

    logic [7:0] tx_data1;
    logic       tx_valid1;
    logic       tx_ready1;
    logic       tx1;
    logic       busy1;

    logic [7:0] tx_data2;
    logic       tx_valid2;
    logic       tx_ready2;
    logic       tx2;
    logic       busy2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx dut1 (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data1),
        .tx_valid (tx_valid1),
        .tx_ready (tx_ready1),
        .tx       (tx1),
        .busy     (busy1)
    );

    uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut2 (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data2),
        .tx_valid (tx_valid2),
        .tx_ready (tx_ready2),
        .tx       (tx2),
        .busy     (busy2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
            $error("check %s differs", tag);
        end
    endtask

    function automatic logic get_tx(input int sel);
        return (sel != 0) ? tx2 : tx1;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel != 0) ? busy2 : busy1;
    endfunction

    function automatic logic get_ready(input int sel);
        return (sel != 0) ? tx_ready2 : tx_ready1;
    endfunction

    task automatic drive(input int sel, input logic v, input logic [7:0] d);
        if (sel != 0) begin
            tx_valid2 = v;
            tx_data2  = d;
        end else begin
            tx_valid1 = v;
            tx_data1  = d;
        end
    endtask

    // Called #1 after the handshake edge. Checks every cycle of the frame.
    // With chain set, the next byte is offered on the final stop cycle.
    task automatic check_frame(input int sel, input logic [7:0] b, input int nstop,
                               input int cpb, input logic chain, input logic [7:0] next_b);
        int flen;
        int slot;
        logic exp;
        flen = (9 + nstop) * cpb;
        for (int i = 0; i < flen; i++) begin
            slot = i / cpb;
            if (slot == 0)      exp = 1'b0;
            else if (slot <= 8) exp = b[slot-1];
            else                exp = 1'b1;
            chk($sformatf("tx_b%02h_c%0d", b, i), {31'd0, get_tx(sel)}, {31'd0, exp});
            chk($sformatf("busy_b%02h_c%0d", b, i), {31'd0, get_busy(sel)}, 32'd1);
            if (i == flen - 1 && chain)
                drive(sel, 1'b1, next_b);
            else
                drive(sel, 1'b0, 8'($urandom));   // data noise without valid
            tick();
        end
        drive(sel, 1'b0, 8'h00);
    endtask

    task automatic check_idle(input int sel, input string tag);
        chk({tag, "_tx"},    {31'd0, get_tx(sel)},    32'd1);
        chk({tag, "_busy"},  {31'd0, get_busy(sel)},  32'd0);
        chk({tag, "_ready"}, {31'd0, get_ready(sel)}, 32'd1);
    endtask

    initial begin
        logic [7:0] seq [3];
        int         fr;
        int         slot;
        logic       exp;
        logic       exp_rdy;

        reset = 1'b1;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        tick();
        tick();

        // Reset state
        chk("rst_tx1",    {31'd0, tx1},       32'd1);
        chk("rst_busy1",  {31'd0, busy1},     32'd0);
        chk("rst_ready1", {31'd0, tx_ready1}, 32'd0);
        chk("rst_tx2",    {31'd0, tx2},       32'd1);
        chk("rst_ready2", {31'd0, tx_ready2}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_ready1_after", {31'd0, tx_ready1}, 32'd1);
        tick();

        // 0x55 single frame
        drive(0, 1'b1, 8'h55);
        tick();
        chk("ready_after_idle_hs", {31'd0, tx_ready1}, 32'd1);
        check_frame(0, 8'h55, 1, 32, 1'b0, 8'h00);
        check_idle(0, "after55");
        for (int i = 0; i < 5; i++) begin
            chk("idle55_tx", {31'd0, tx1}, 32'd1);
            tick();
        end

        // 0xA3, 0x00, 0xFF offered each on the last stop cycle of the previous
        drive(0, 1'b1, 8'hA3);
        tick();
        check_frame(0, 8'hA3, 1, 32, 1'b1, 8'h00);
        check_frame(0, 8'h00, 1, 32, 1'b1, 8'hFF);
        check_frame(0, 8'hFF, 1, 32, 1'b0, 8'h00);
        check_idle(0, "afterFF");
        tick();

        // Handshake on final stop cycle with empty buffer: 0x11 then 0x7E
        drive(0, 1'b1, 8'h11);
        tick();
        check_frame(0, 8'h11, 1, 32, 1'b1, 8'h7E);
        check_frame(0, 8'h7E, 1, 32, 1'b0, 8'h00);
        check_idle(0, "after7E");
        tick();

        // tx_valid held: 0x3C, 0xC3, 0x81 back to back
        seq[0] = 8'h3C;
        seq[1] = 8'hC3;
        seq[2] = 8'h81;
        drive(0, 1'b1, 8'h3C);
        tick();
        for (int c = 0; c < 960; c++) begin
            fr   = c / 320;
            slot = (c % 320) / 32;
            if (slot == 0)      exp = 1'b0;
            else if (slot <= 8) exp = seq[fr][slot-1];
            else                exp = 1'b1;
            if (c == 0 || c == 320 || c >= 640) exp_rdy = 1'b1;
            else                                exp_rdy = 1'b0;
            chk($sformatf("chain_tx_c%0d", c),    {31'd0, tx1},       {31'd0, exp});
            chk($sformatf("chain_busy_c%0d", c),  {31'd0, busy1},     32'd1);
            chk($sformatf("chain_ready_c%0d", c), {31'd0, tx_ready1}, {31'd0, exp_rdy});
            if (c == 0)   drive(0, 1'b1, 8'hC3);
            if (c == 1)   drive(0, 1'b1, 8'h81);
            if (c == 321) drive(0, 1'b0, 8'h00);
            tick();
        end
        check_idle(0, "after_chain");
        tick();

        // Reset mid-frame with a byte buffered
        drive(0, 1'b1, 8'h12);
        tick();
        drive(0, 1'b1, 8'h34);
        tick();
        chk("buf_full_ready", {31'd0, tx_ready1}, 32'd0);
        drive(0, 1'b0, 8'h00);
        for (int c = 2; c < 100; c++) tick();
        reset = 1'b1;
        #1;
        chk("rst_mid_ready_low", {31'd0, tx_ready1}, 32'd0);
        tick();
        chk("rst_mid_tx",   {31'd0, tx1},   32'd1);
        chk("rst_mid_busy", {31'd0, busy1}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_mid_ready", {31'd0, tx_ready1}, 32'd1);
        for (int c = 0; c < 400; c++) begin
            chk("post_rst_tx",   {31'd0, tx1},   32'd1);
            chk("post_rst_busy", {31'd0, busy1}, 32'd0);
            tick();
        end
        drive(0, 1'b1, 8'h5A);
        tick();
        check_frame(0, 8'h5A, 1, 32, 1'b0, 8'h00);
        check_idle(0, "after5A");

        // 2 stop bits, 4 clocks/bit: 0x01 -> 44-cycle frame
        drive(1, 1'b1, 8'h01);
        tick();
        check_frame(1, 8'h01, 2, 4, 1'b0, 8'h00);
        check_idle(1, "after01");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
